// File: rtl/regseq_pkg.sv
// Shared definitions for the register-bank sequencer: op encoding, FSM states,
// default datapath/index widths.
package regseq_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MOVE = 2'b11;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StIssue = 3'd1,
        StWait  = 3'd2,
        StExec  = 3'd3,
        StWrite = 3'd4,
        StResp  = 3'd5
    } state_e;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/MOVE modulo 2^DATA_W, plus
// a zero flag on the result. No carry or overflow is produced.
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    // Select the operation result; MOVE passes operand A through.
    always_comb begin
        result_o = '0;
        unique case (op_i)
            OP_ADD:  result_o = opa_i + opb_i;
            OP_SUB:  result_o = opa_i - opb_i;
            OP_AND:  result_o = opa_i & opb_i;
            OP_MOVE: result_o = opa_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/regbank_sequencer.sv
// Register-bank sequencer: accepts one host command, reads rs/rt from the bank,
// computes the result, writes it to rd and returns it to the host.
// Optional build macro: REGSEQ_ZERO_GUARD_EN suppresses the bank write when rd==0
// (the WRITE state is still traversed, the result is still returned).
module regbank_sequencer
    import regseq_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned BANK_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic [ADDR_W-1:0] readRegA,
    output logic [ADDR_W-1:0] readRegB,
    output logic [ADDR_W-1:0] writeReg,
    output logic              readWrite,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] dataReadA,
    input  logic [DATA_W-1:0] dataReadB
);

    // WAIT lasts BANK_LAT cycles; the counter starts one below that.
    localparam logic [1:0] LatInit = 2'(BANK_LAT - 1);

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [1:0]          lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;

    // Registered outputs; the read-address registers double as the rs/rt latches.
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]   read_reg_a_q, read_reg_a_d;
    logic [ADDR_W-1:0]   read_reg_b_q, read_reg_b_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic                read_write_q, read_write_d;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                write_en;

`ifdef REGSEQ_ZERO_GUARD_EN
    assign write_en = (rd_q != '0);
`else
    assign write_en = 1'b1;
`endif

    regseq_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Next-state, datapath latches and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        lat_cnt_d    = lat_cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        result_d     = result_q;
        zero_d       = zero_q;
        read_reg_a_d = read_reg_a_q;
        read_reg_b_d = read_reg_b_q;
        write_reg_d  = write_reg_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d         = cmd_op;
                    rd_d         = cmd_rd;
                    read_reg_a_d = cmd_rs;
                    read_reg_b_d = cmd_rt;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                lat_cnt_d = LatInit;
                state_d   = StWait;
            end
            StWait: begin
                if (lat_cnt_q == '0) begin
                    opa_d   = dataReadA;
                    opb_d   = dataReadB;
                    state_d = StExec;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            StExec: begin
                result_d    = alu_result;
                zero_d      = alu_zero;
                write_reg_d = rd_q;
                state_d     = StWrite;
            end
            StWrite: begin
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs follow the state being entered so they are valid for its whole cycle.
        cmd_ready_d  = (state_d == StIdle);
        rsp_valid_d  = (state_d == StResp);
        read_write_d = (state_d == StWrite) && write_en;
    end

    // State, latches and output registers; clear abandons any transaction at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= StIdle;
            op_q         <= '0;
            rd_q         <= '0;
            lat_cnt_q    <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            read_reg_a_q <= '0;
            read_reg_b_q <= '0;
            write_reg_q  <= '0;
            read_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            lat_cnt_q    <= lat_cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            read_reg_a_q <= read_reg_a_d;
            read_reg_b_q <= read_reg_b_d;
            write_reg_q  <= write_reg_d;
            read_write_q <= read_write_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = result_q;
    assign rsp_zero  = zero_q;
    assign readRegA  = read_reg_a_q;
    assign readRegB  = read_reg_b_q;
    assign writeReg  = write_reg_q;
    assign readWrite = read_write_q;
    assign writeData = result_q;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Bench for regbank_sequencer: bank model, reference register file, response and
// write scoreboards, directed cases followed by randomized commands.
module tb_regbank_sequencer;

    localparam int unsigned BankLat = 1;

`ifdef REGSEQ_ZERO_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic [4:0]  readRegA, readRegB, writeReg;
    logic        readWrite;
    logic [31:0] writeData, dataReadA, dataReadB;

    always #5 clock = ~clock;

    regbank_sequencer #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .BANK_LAT (BankLat)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_rd    (cmd_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .readRegA  (readRegA),
        .readRegB  (readRegB),
        .writeReg  (writeReg),
        .readWrite (readWrite),
        .writeData (writeData),
        .dataReadA (dataReadA),
        .dataReadB (dataReadB)
    );

    // Bank model: synchronous one-cycle read, write on readWrite, read-before-write.
    logic [31:0] bank [32];
    logic        bank_init;
    always @(posedge clock) begin
        if (bank_init) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'(2 * i);
        end else if (readWrite) begin
            bank[writeReg] <= writeData;
        end
        dataReadA <= bank[readRegA];
        dataReadB <= bank[readRegB];
    end

    typedef struct { logic [31:0] data; logic zero; } rsp_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [31:0] ref_regs [32];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            default: return a;
        endcase
    endfunction

    // Response monitor: a handshake happens at the next posedge.
    always @(negedge clock) begin
        if (!clear && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            end
        end
    end

    // Write monitor: each sampled readWrite cycle must match one expected write.
    always @(negedge clock) begin
        if (readWrite) begin
            if (wr_q.size() == 0) begin
                check("write_unexpected", 32'(readWrite), 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("write_reg", 32'(writeReg), 32'(w.addr));
                check("write_data", writeData, w.data);
            end
        end
    end

    task automatic accept_cmd(input int op, input int rs, input int rt, input int rd);
        int w;
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_op = 2'(op); cmd_rs = 5'(rs); cmd_rt = 5'(rt); cmd_rd = 5'(rd);
        w = 0;
        @(negedge clock);
        while (!cmd_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("cmd_ready_accept", 32'(cmd_ready), 32'd1);
        @(posedge clock); #1;
        // Busy-time field changes must be ignored.
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom_range(0, 3));
        cmd_rs = 5'($urandom); cmd_rt = 5'($urandom); cmd_rd = 5'($urandom);
    endtask

    task automatic issue(input int op, input int rs, input int rt, input int rd, input int hold);
        logic [31:0] res;
        logic [31:0] held;
        int k;
        res = model(op, ref_regs[rs], ref_regs[rt]);
        rsp_q.push_back('{data: res, zero: (res == 32'd0)});
        if (!(Guard && rd == 0)) begin
            wr_q.push_back('{addr: 5'(rd), data: res});
            ref_regs[rd] = res;
        end
        rsp_ready = (hold == 0);
        accept_cmd(op, rs, rt, rd);
        // Count falling edges after the accept edge until rsp_valid is seen.
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 1) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        end while (!rsp_valid && k < 40);
        check("latency", k, BankLat + 4);
        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_data, held);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        if (hold > 0) begin
            @(posedge clock); #1;
            rsp_ready = 1'b1;
            @(negedge clock);
        end
        @(posedge clock);
        @(negedge clock);
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1;
        bank_init = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'(2 * i);
        repeat (2) @(posedge clock);
        #1 bank_init = 1'b0;
        @(negedge clock);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_read_write", 32'(readWrite), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_read_reg_a", 32'(readRegA), 32'd0);
        check("rst_write_reg", 32'(writeReg), 32'd0);
        @(posedge clock); #1 clear = 1'b0;

        // Directed cases.
        issue(0, 3, 5, 10, 0);
        check("t1_bank10", bank[10], 32'd16);
        issue(1, 2, 7, 9, 0);
        check("t2_bank9", bank[9], 32'hFFFF_FFF6);
        issue(1, 4, 4, 11, 0);
        issue(3, 31, 0, 1, 0);
        issue(0, 1, 1, 2, 0);
        check("t3_bank1", bank[1], 32'd62);
        check("t3_bank2", bank[2], 32'd124);
        issue(0, 6, 6, 6, 3);
        check("t4_bank6", bank[6], 32'd24);

        // Clear during WAIT: transaction abandoned, nothing written.
        accept_cmd(0, 7, 8, 12);
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check("clr_read_write", 32'(readWrite), 32'd0);
        check("clr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("clr_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        repeat (8) @(negedge clock);
        check("clr_bank12", bank[12], 32'd24);
        issue(0, 7, 8, 13, 0);

        // AND into register 0.
        issue(2, 3, 5, 0, 0);
        check("t6_bank0", bank[0], Guard ? 32'd0 : 32'd2);

        // Randomized commands.
        for (int n = 0; n < 150; n++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clock);
        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 32; i++) if (bank[i] !== ref_regs[i]) bad++;
            check("bank_final", 32'(bad), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
